chacha_round_sched: RTL and testbench

CHACHA_ROUND_SCHED -- requirements
Module: chacha_round_sched

---
 rtl/chacha_round_sched.sv | 156 +++++++++++++++
 tb/tb_chacha_round_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/chacha_round_sched.sv
// ChaCha round scheduler: issues column/diagonal quarter-round indices, then
// sequences the 16-word feed-forward addition and pulses done/ctr_inc.
module chacha_round_sched #(
    parameter int ROUNDS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       qr_ready,
    input  logic       qr_done,
    output logic       qr_valid,
    output logic [3:0] qr_a,
    output logic [3:0] qr_b,
    output logic [3:0] qr_c,
    output logic [3:0] qr_d,
    output logic [4:0] round,
    output logic       add_en,
    output logic [3:0] add_idx,
    output logic       ready,
    output logic       done,
    output logic       ctr_inc
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADD, DONE} state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t      state_reg;
    logic [1:0]  sel_reg;
    logic [4:0]  round_reg;
    logic [15:0] idx_reg;
    logic        qr_valid_reg;
    logic        add_en_reg;
    logic [3:0]  add_idx_reg;
    logic        ready_reg;
    logic        done_reg;
    logic        ctr_inc_reg;

    // Lane k always touches words 4k..4k+3; odd (diagonal) rounds rotate
    // the column offset of lane k by k.
    function automatic logic [15:0] qr_indices(input logic [4:0] r, input logic [1:0] s);
        logic [15:0] v;
        logic [1:0]  lane;
        logic [1:0]  off;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            lane = 2'(k);
            off  = r[0] ? (s + lane) : s;
            v[4*k +: 4] = {lane, off};
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            round_reg    <= '0;
            idx_reg      <= '0;
            qr_valid_reg <= 1'b0;
            add_en_reg   <= 1'b0;
            add_idx_reg  <= '0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            ctr_inc_reg  <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            ctr_inc_reg <= 1'b0;
            if (abort) begin
                state_reg    <= IDLE;
                sel_reg      <= '0;
                round_reg    <= '0;
                idx_reg      <= '0;
                qr_valid_reg <= 1'b0;
                add_en_reg   <= 1'b0;
                add_idx_reg  <= '0;
                ready_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg    <= ISSUE;
                            sel_reg      <= '0;
                            round_reg    <= '0;
                            idx_reg      <= qr_indices(5'd0, 2'd0);
                            qr_valid_reg <= 1'b1;
                            ready_reg    <= 1'b0;
                        end
                    end
                    ISSUE: begin
                        if (qr_ready) begin
                            state_reg    <= WAIT;
                            qr_valid_reg <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (qr_done) begin
                            if (sel_reg != 2'd3) begin
                                state_reg    <= ISSUE;
                                sel_reg      <= sel_reg + 2'd1;
                                idx_reg      <= qr_indices(round_reg, sel_reg + 2'd1);
                                qr_valid_reg <= 1'b1;
                            end else if (round_reg != LAST_ROUND) begin
                                state_reg    <= ISSUE;
                                sel_reg      <= '0;
                                round_reg    <= round_reg + 5'd1;
                                idx_reg      <= qr_indices(round_reg + 5'd1, 2'd0);
                                qr_valid_reg <= 1'b1;
                            end else begin
                                state_reg   <= ADD;
                                sel_reg     <= '0;
                                round_reg   <= '0;
                                idx_reg     <= '0;
                                add_en_reg  <= 1'b1;
                                add_idx_reg <= '0;
                            end
                        end
                    end
                    ADD: begin
                        if (add_idx_reg == 4'd15) begin
                            state_reg   <= DONE;
                            add_en_reg  <= 1'b0;
                            add_idx_reg <= '0;
                            done_reg    <= 1'b1;
                            ctr_inc_reg <= 1'b1;
                        end else begin
                            add_idx_reg <= add_idx_reg + 4'd1;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign qr_valid = qr_valid_reg;
    assign qr_a     = idx_reg[3:0];
    assign qr_b     = idx_reg[7:4];
    assign qr_c     = idx_reg[11:8];
    assign qr_d     = idx_reg[15:12];
    assign round    = round_reg;
    assign add_en   = add_en_reg;
    assign add_idx  = add_idx_reg;
    assign ready    = ready_reg;
    assign done     = done_reg;
    assign ctr_inc  = ctr_inc_reg;

endmodule

// File: tb/tb_chacha_round_sched.sv
// Randomised bench for chacha_round_sched: quarter-round responder with
// stalls and variable write-back delay, checked against a tuple-table model.
module tb_chacha_round_sched;

    logic       clk = 1'b0;
    logic       rst, start, abort, qr_ready, qr_done;
    logic       qr_valid, add_en, ready, done, ctr_inc;
    logic [3:0] qr_a, qr_b, qr_c, qr_d, add_idx;
    logic [4:0] round;

    int total = 0;
    int bad   = 0;

    chacha_round_sched #(.ROUNDS(20)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .qr_ready(qr_ready), .qr_done(qr_done), .qr_valid(qr_valid),
        .qr_a(qr_a), .qr_b(qr_b), .qr_c(qr_c), .qr_d(qr_d),
        .round(round), .add_en(add_en), .add_idx(add_idx),
        .ready(ready), .done(done), .ctr_inc(ctr_inc)
    );

    always #5 clk = ~clk;

    // Diagonal tuples packed {d,c,b,a}
    localparam logic [15:0] DIAG [4] = '{16'hFA50, 16'hCB61, 16'hD872, 16'hE943};

    function automatic logic [15:0] model_tuple(input int k);
        int r, s;
        r = k / 4;
        s = k % 4;
        if (r % 2 == 0)
            return {4'(12 + s), 4'(8 + s), 4'(4 + s), 4'(s)};
        return DIAG[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 1);
        check({tag, "_qrv"}, 32'(qr_valid), 0);
        check({tag, "_addv"}, {add_en, done, ctr_inc}, 0);
        check({tag, "_round"}, 32'(round), 0);
        check({tag, "_addidx"}, 32'(add_idx), 0);
        check({tag, "_idx"}, {qr_d, qr_c, qr_b, qr_a}, 0);
    endtask

    // One block: stall = random qr_ready/delays, abort_rnd >= 0 aborts in WAIT
    // of that round, rst_idx >= 0 resets during ADD, timed checks exact latency.
    task automatic run_block(input bit stall, input int abort_rnd, input int rst_idx, input bit timed);
        int cyc, n_acc, cnt, add_n, first_add;
        bit finished, got_done, abort_next, aborting, prev_stall;
        logic [15:0] cur, prev_tuple;
        @(negedge clk);
        check("idle_ready", 32'(ready), 1);
        start = 1; abort = 0; qr_ready = 0; qr_done = 0;
        cyc = 0; n_acc = 0; cnt = 0; add_n = 0; first_add = -1;
        finished = 0; got_done = 0; abort_next = 0; aborting = 0; prev_stall = 0;
        prev_tuple = '0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (aborting) begin
                check("abort_idle_ready", 32'(ready), 1);
                check("abort_qrv", 32'(qr_valid), 0);
                check("abort_round", 32'(round), 0);
                check("abort_no_done", {done, ctr_inc}, 0);
                abort = 0; start = 0; qr_done = 0; finished = 1;
            end else if (abort_next) begin
                check("abort_in_wait", 32'(qr_valid), 0);
                abort = 1; qr_done = 1; qr_ready = 1; start = 1;
                aborting = 1;
            end else begin
                start = ($urandom_range(0, 7) == 0);
                check("busy_ready", 32'(ready), 0);
                check("ctr_inc_eq_done", 32'(ctr_inc), 32'(done));
                qr_done = 0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) qr_done = 1;
                end else if ($urandom_range(0, 3) == 0) begin
                    qr_done = 1;
                end
                qr_ready = stall ? (cyc > 5 && $urandom_range(0, 2) != 0) : 1'b1;
                if (qr_valid) begin
                    cur = {qr_d, qr_c, qr_b, qr_a};
                    if (prev_stall) check("hold_idx", cur, prev_tuple);
                    prev_tuple = cur;
                    prev_stall = !qr_ready;
                    if (qr_ready) begin
                        $display("accept %0d round=%0d idx=(%0d,%0d,%0d,%0d)",
                                 n_acc, round, qr_a, qr_b, qr_c, qr_d);
                        check("qr_idx", cur, model_tuple(n_acc));
                        check("qr_round", 32'(round), n_acc / 4);
                        if (abort_rnd >= 0 && n_acc == 4 * abort_rnd + 1) abort_next = 1;
                        n_acc++;
                        cnt = timed ? 1 : $urandom_range(1, 3);
                    end
                end else begin
                    prev_stall = 0;
                end
                if (add_en) begin
                    if (first_add < 0) first_add = cyc;
                    check("add_idx", 32'(add_idx), add_n);
                    add_n++;
                    if (rst_idx >= 0 && add_idx == 4'(rst_idx)) begin
                        rst = 1;
                        #1;
                        check_reset_outputs("rst_in_add");
                        rst = 0; start = 0; qr_done = 0; qr_ready = 0;
                        finished = 1;
                    end
                end
                if (done && !finished) begin
                    check("done_acc", n_acc, 80);
                    check("done_adds", add_n, 16);
                    check("done_ctr_inc", 32'(ctr_inc), 1);
                    if (timed) begin
                        check("first_add_cycle", first_add, 161);
                        check("done_cycle", cyc, 177);
                    end
                    $display("block done cycle=%0d accepts=%0d", cyc, n_acc);
                    start = 0;
                    got_done = 1;
                    finished = 1;
                end
            end
        end
        if (!finished) check("block_timeout", 0, 1);
        if (got_done) begin
            @(negedge clk);
            check("ready_after_done", 32'(ready), 1);
            check("done_one_cycle", 32'(done), 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; qr_ready = 0; qr_done = 0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 0;

        run_block(1'b0, -1, -1, 1'b1);
        run_block(1'b1, -1, -1, 1'b0);
        run_block(1'b1, 7, -1, 1'b0);
        run_block(1'b0, -1, -1, 1'b0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        check("start_abort_idle_ready", 32'(ready), 1);
        check("start_abort_idle_qrv", 32'(qr_valid), 0);
        $display("start+abort in idle ready=%0d qr_valid=%0d", ready, qr_valid);

        run_block(1'b1, -1, 9, 1'b0);
        run_block(1'b0, -1, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
